// File: rtl/camo_key_loader.sv
// ---------------------------------------------------------------------------
// camo_key_loader
//
// Fetches the camouflage key for the locked c432 netlist from the on-die key
// store. The key arrives as a bit-serial valid/ready stream, LSB first: the
// key bits come first, then a nibble checksum. The checksum is the XOR of the
// key nibbles. If the checksum is bad, the fetch is retried a bounded number
// of times before the block latches a sticky error. Only a verified key ever
// reaches key_out. The netlist's outputs are gated by out_enable.
//
// Ports
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   start       : level; begins a fetch when sampled in IDLE
//   zeroize     : level; clears key/state back to IDLE, highest priority
//   kbit_valid  : key store presents a bit on kbit
//   kbit        : serial key/checksum bit, LSB first
//   kbit_ready  : loader accepts a bit this cycle (zeroize masks it)
//   fetch_req   : asks the store to (re)start its stream from bit 0
//   key_out     : verified key, bit i drives s_i
//   key_valid   : key_out holds a verified key
//   out_enable  : output gate for the locked netlist, equals key_valid
//   busy        : fetch in progress (REQ, SHIFT, CHECK)
//   error       : sticky, all attempts failed
// ---------------------------------------------------------------------------
module camo_key_loader #(
    parameter int KEY_W   = 12,
    parameter int CHK_W   = 4,
    parameter int MAX_TRY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             zeroize,
    input  logic             kbit_valid,
    input  logic             kbit,
    output logic             kbit_ready,
    output logic             fetch_req,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             out_enable,
    output logic             busy,
    output logic             error
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [4:0] LAST_BIT_C = 5'(KEY_W + CHK_W - 1);
    localparam logic [4:0] KEY_W_C    = 5'(KEY_W);
    localparam logic [2:0] MAX_TRY_C  = 3'(MAX_TRY);

    // XOR of all key nibbles; this is the checksum the store appends
    function automatic logic [CHK_W-1:0] nibble_xor(input logic [KEY_W-1:0] key);
        logic [CHK_W-1:0] acc;
        acc = {CHK_W{1'b0}};
        for (int i = 0; i < KEY_W / 4; i++) begin
            acc = acc ^ key[i*4 +: 4];
        end
        return acc;
    endfunction

    state_t             state_r;
    logic [4:0]         bit_cnt_r;
    logic [2:0]         try_cnt_r;
    logic [KEY_W-1:0]   shadow_key_r;
    logic [CHK_W-1:0]   shadow_chk_r;
    logic [KEY_W-1:0]   key_out_r;
    logic               key_valid_r;
    logic               error_r;
    logic               ready_r;
    logic               fetch_req_r;
    logic               busy_r;

    logic               accept_s;
    logic               chk_ok_s;

    // zeroize masks ready in the same cycle, so a bit offered alongside it is never taken
    assign kbit_ready = ready_r & ~zeroize;
    assign accept_s   = kbit_valid & kbit_ready;
    assign chk_ok_s   = (nibble_xor(shadow_key_r) == shadow_chk_r);

    assign fetch_req  = fetch_req_r;
    assign key_out    = key_out_r;
    assign key_valid  = key_valid_r;
    assign out_enable = key_valid_r;
    assign busy       = busy_r;
    assign error      = error_r;

    // Sequencer: state, counters, shadow registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 5'd0;
            try_cnt_r    <= 3'd0;
            shadow_key_r <= {KEY_W{1'b0}};
            shadow_chk_r <= {CHK_W{1'b0}};
            key_out_r    <= {KEY_W{1'b0}};
            key_valid_r  <= 1'b0;
            error_r      <= 1'b0;
            ready_r      <= 1'b0;
            fetch_req_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else if (zeroize) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 5'd0;
            try_cnt_r    <= 3'd0;
            shadow_key_r <= {KEY_W{1'b0}};
            shadow_chk_r <= {CHK_W{1'b0}};
            key_out_r    <= {KEY_W{1'b0}};
            key_valid_r  <= 1'b0;
            error_r      <= 1'b0;
            ready_r      <= 1'b0;
            fetch_req_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r     <= ST_REQ;
                        try_cnt_r   <= 3'd1;
                        bit_cnt_r   <= 5'd0;
                        fetch_req_r <= 1'b1;
                        busy_r      <= 1'b1;
                        ready_r     <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    state_r     <= ST_SHIFT;
                    ready_r     <= 1'b1;
                    fetch_req_r <= 1'b1;
                    busy_r      <= 1'b1;
                end
                ST_SHIFT: begin
                    if (accept_s) begin
                        // LSB first: each new bit enters at the top and walks down
                        if (bit_cnt_r < KEY_W_C) begin
                            shadow_key_r <= {kbit, shadow_key_r[KEY_W-1:1]};
                        end else begin
                            shadow_chk_r <= {kbit, shadow_chk_r[CHK_W-1:1]};
                        end
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        if (bit_cnt_r == LAST_BIT_C) begin
                            state_r     <= ST_CHECK;
                            ready_r     <= 1'b0;
                            fetch_req_r <= 1'b0;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_CHECK: begin
                    if (chk_ok_s) begin
                        state_r     <= ST_DONE;
                        key_out_r   <= shadow_key_r;
                        key_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (try_cnt_r < MAX_TRY_C) begin
                        // fetch_req was low for this CHECK cycle: that gap is the store's restart cue
                        state_r     <= ST_REQ;
                        try_cnt_r   <= try_cnt_r + 3'd1;
                        bit_cnt_r   <= 5'd0;
                        fetch_req_r <= 1'b1;
                    end else begin
                        state_r   <= ST_ERR;
                        error_r   <= 1'b1;
                        key_out_r <= {KEY_W{1'b0}};
                        busy_r    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                ST_ERR: begin
                    state_r <= ST_ERR;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    key_out_r   <= {KEY_W{1'b0}};
                    key_valid_r <= 1'b0;
                    ready_r     <= 1'b0;
                    fetch_req_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camo_key_loader.sv
// ---------------------------------------------------------------------------
// tb_camo_key_loader
//
// Directed bench for camo_key_loader. The stimulus process pushes the expected
// result (key, flags, latency from the start edge) into a scoreboard queue.
// The monitor process pops an entry whenever key_valid or error rises and
// compares it against the DUT outputs. Every cycle, the monitor also checks
// that out_enable tracks key_valid and that no key is exposed before DONE.
// ---------------------------------------------------------------------------
module tb_camo_key_loader;

    typedef struct {
        logic [11:0] key;
        logic        valid;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        zeroize;
    logic        kbit_valid;
    logic        kbit;
    logic        kbit_ready;
    logic        fetch_req;
    logic [11:0] key_out;
    logic        key_valid;
    logic        out_enable;
    logic        busy;
    logic        error;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    logic prev_kv = 1'b0;
    logic prev_err = 1'b0;

    camo_key_loader #(.KEY_W(12), .CHK_W(4), .MAX_TRY(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .zeroize    (zeroize),
        .kbit_valid (kbit_valid),
        .kbit       (kbit),
        .kbit_ready (kbit_ready),
        .fetch_req  (fetch_req),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .out_enable (out_enable),
        .busy       (busy),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".key_out"},    32'(key_out),    32'h0);
        chk({tag, ".key_valid"},  32'(key_valid),  32'h0);
        chk({tag, ".out_enable"}, 32'(out_enable), 32'h0);
        chk({tag, ".kbit_ready"}, 32'(kbit_ready), 32'h0);
        chk({tag, ".fetch_req"},  32'(fetch_req),  32'h0);
        chk({tag, ".busy"},       32'(busy),       32'h0);
        chk({tag, ".error"},      32'(error),      32'h0);
    endtask

    task automatic push_exp(input logic [11:0] key, input logic valid, input logic err, input int lat);
        exp_t e;
        e.key = key; e.valid = valid; e.err = err; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic do_zeroize(input string tag);
        @(negedge clk); zeroize = 1'b1;
        @(negedge clk); zeroize = 1'b0;
        check_idle(tag);
    endtask

    // Drive one bit at a negedge and hold it until a posedge sees ready high
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        @(negedge clk); kbit_valid = 1'b1; kbit = b;
        while (!kbit_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_chk++; n_fail++;
            $display("FAIL send_bit_timeout: kbit_ready stayed %0b, required 1", kbit_ready);
        end
    endtask

    // bits = {checksum, key}; stall inserts a valid-low cycle carrying a decoy bit
    task automatic send_stream(input logic [15:0] bits, input int nbits, input bit stall);
        for (int i = 0; i < nbits; i++) begin
            if (stall && i > 0) begin
                @(negedge clk); kbit_valid = 1'b0; kbit = ~bits[i];
            end
            send_bit(bits[i]);
        end
        @(negedge clk); kbit_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s.result_timeout: %0d results still pending, required 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: pops the scoreboard on every rising key_valid or error
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("oe_tracks_kv", 32'(out_enable), 32'(key_valid));
            if (!key_valid) chk("key_hidden", 32'(key_out), 32'h0);
            if ((key_valid && !prev_kv) || (error && !prev_err)) begin
                if (sb_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_result: key_valid=%0b error=%0b, required no result", key_valid, error);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb.key_out",    32'(key_out),    32'(e.key));
                    chk("sb.key_valid",  32'(key_valid),  32'(e.valid));
                    chk("sb.out_enable", 32'(out_enable), 32'(e.valid));
                    chk("sb.error",      32'(error),      32'(e.err));
                    chk("sb.busy",       32'(busy),       32'h0);
                    chk("sb.latency",    32'(cyc - start_cyc), 32'(e.lat));
                end
            end
            prev_kv  = key_valid;
            prev_err = error;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; zeroize = 1'b0; kbit_valid = 1'b0; kbit = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Good key 12'hA5C, checksum 4'h3, valid held high
        push_exp(12'hA5C, 1'b1, 1'b0, 18);
        do_start();
        send_stream({4'h3, 12'hA5C}, 16, 1'b0);
        wait_result("good");

        // start is ignored in DONE
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("done.busy",      32'(busy),      32'h0);
        chk("done.fetch_req", 32'(fetch_req), 32'h0);
        chk("done.key_valid", 32'(key_valid), 32'h1);
        chk("done.key_out",   32'(key_out),   32'hA5C);
        do_zeroize("zero_done");

        // Same stream with valid toggling
        push_exp(12'hA5C, 1'b1, 1'b0, 33);
        do_start();
        send_stream({4'h3, 12'hA5C}, 16, 1'b1);
        wait_result("stall");
        do_zeroize("zero_stall");

        // Retry: bad checksum first, then good
        push_exp(12'hA5C, 1'b1, 1'b0, 36);
        do_start();
        send_stream({4'h0, 12'hA5C}, 16, 1'b0);
        chk("gap.fetch_req",  32'(fetch_req),  32'h0);
        chk("gap.busy",       32'(busy),       32'h1);
        chk("gap.kbit_ready", 32'(kbit_ready), 32'h0);
        @(negedge clk);
        chk("req.fetch_req",  32'(fetch_req),  32'h1);
        chk("req.kbit_ready", 32'(kbit_ready), 32'h0);
        send_stream({4'h3, 12'hA5C}, 16, 1'b0);
        wait_result("retry");
        chk("retry.error", 32'(error), 32'h0);
        do_zeroize("zero_retry");

        // Exhausted retries
        push_exp(12'h000, 1'b0, 1'b1, 54);
        do_start();
        send_stream({4'h0, 12'hA5C}, 16, 1'b0);
        send_stream({4'h7, 12'hA5C}, 16, 1'b0);
        send_stream({4'hF, 12'hA5C}, 16, 1'b0);
        wait_result("exhaust");
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("err.error",     32'(error),     32'h1);
        chk("err.key_out",   32'(key_out),   32'h0);
        chk("err.busy",      32'(busy),      32'h0);
        chk("err.fetch_req", 32'(fetch_req), 32'h0);
        do_zeroize("zero_err");

        // Zeroize mid-SHIFT coincident with an offered bit, then reload
        do_start();
        send_stream({4'h3, 12'hA5C}, 5, 1'b0);
        @(negedge clk);
        chk("mid.kbit_ready_pre", 32'(kbit_ready), 32'h1);
        kbit_valid = 1'b1; kbit = 1'b1; zeroize = 1'b1;
        #1;
        chk("mid.kbit_ready_zero", 32'(kbit_ready), 32'h0);
        @(negedge clk); zeroize = 1'b0; kbit_valid = 1'b0;
        check_idle("zero_mid");
        push_exp(12'h3F1, 1'b1, 1'b0, 18);
        do_start();
        send_stream({4'hD, 12'h3F1}, 16, 1'b0);
        wait_result("reload");
        do_zeroize("zero_reload");

        // Async reset mid-SHIFT between edges
        do_start();
        send_stream({4'h3, 12'hA5C}, 5, 1'b0);
        chk("ar.busy_pre", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk); rst_n = 1'b1;
        push_exp(12'h3F1, 1'b1, 1'b0, 18);
        do_start();
        send_stream({4'hD, 12'h3F1}, 16, 1'b0);
        wait_result("after_rst");

        chk("sb.empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
